// File: rtl/data_mem_pipe_pkg.sv
// Shared definitions for the pipelined data memory: lane/width helpers and
// error codes also used by the core's load/store unit.
package data_mem_pipe_pkg;

    typedef enum logic [1:0] {
        ERR_NONE     = 2'd0,
        ERR_MISALIGN = 2'd1,
        ERR_RANGE    = 2'd2
    } mem_err_e;

    localparam int ERR_CODE_W = 2;

    function automatic int lanes_f(input int data_w);
        return data_w / 8;
    endfunction

    function automatic int clog2_f(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

    // Response payload is the data word plus one error flag.
    function automatic int rsp_w_f(input int data_w);
        return data_w + 1;
    endfunction

endpackage

// File: rtl/data_mem_pipe_rsp_fifo.sv
// Count-tracked response FIFO; pointers wrap modulo DEPTH so any depth >= 1 works.
module data_mem_pipe_rsp_fifo
    import data_mem_pipe_pkg::*;
#(
    parameter int WIDTH = 33,
    parameter int DEPTH = 2
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            push_i,
    input  logic                            pop_i,
    input  logic [WIDTH-1:0]                data_i,
    output logic [WIDTH-1:0]                data_o,
    output logic                            full_o,
    output logic                            empty_o,
    output logic [clog2_f(DEPTH+1)-1:0]     count_o
);

    localparam int PTR_W = (DEPTH > 1) ? clog2_f(DEPTH) : 1;
    localparam int CNT_W = clog2_f(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] inc_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign full_o  = (cnt_q == CNT_W'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign count_o = cnt_q;
    assign data_o  = mem_q[rd_ptr_q];
    assign do_pop  = pop_i && !empty_o;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (push_i) wr_ptr_d = inc_ptr(wr_ptr_q);
        if (do_pop) rd_ptr_d = inc_ptr(rd_ptr_q);
        if (push_i && !do_pop)      cnt_d = cnt_q + CNT_W'(1);
        else if (do_pop && !push_i) cnt_d = cnt_q - CNT_W'(1);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // When full, a simultaneous pop frees exactly the slot being written.
    always_ff @(posedge clk) begin
        if (push_i) mem_q[wr_ptr_q] <= data_i;
    end

endmodule

// File: rtl/data_mem_pipe.sv
// Data memory with valid/ready request channel, fixed response latency,
// byte-enabled writes, credit-based response buffering and a verify mirror.
module data_mem_pipe
    import data_mem_pipe_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 32,
    parameter int DEPTH       = 1024,
    parameter int LATENCY     = 2,
    parameter int RSP_DEPTH   = 2,
    parameter int VERIFY_WORD = 0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_we,
    input  logic [DATA_W/8-1:0] req_be,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [DATA_W-1:0]   req_wdata,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [DATA_W-1:0]   rsp_rdata,
    output logic                rsp_err,
    output logic [DATA_W-1:0]   verify
);

    localparam int LANES = lanes_f(DATA_W);
    localparam int OFF_W = clog2_f(LANES);
    localparam int IDX_W = (DEPTH > 1) ? clog2_f(DEPTH) : 1;
    localparam int RSP_W = rsp_w_f(DATA_W);
    localparam int CRD_W = clog2_f(RSP_DEPTH + 1);
    localparam int FCN_W = clog2_f(RSP_DEPTH + 1);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] verify_q;
    logic [CRD_W-1:0]  crd_q, crd_d;
    logic [LATENCY-1:0] vld_q, vld_d;
    logic [RSP_W-1:0]  rsp_q [LATENCY];

    logic              acc, pop, wr_en, err;
    mem_err_e          err_code;
    logic [ADDR_W-1:0] word_idx;
    logic [IDX_W-1:0]  mem_idx;
    logic [DATA_W-1:0] cur_word, merged_word, rsp_word;

    logic              fifo_push, fifo_full, fifo_empty;
    logic [FCN_W-1:0]  fifo_cnt;
    logic [RSP_W-1:0]  fifo_head;

    assign req_ready = (crd_q != '0);
    assign acc       = req_valid && req_ready;
    assign pop       = rsp_valid && rsp_ready;

    // Request decode: word index, error classification, byte merge.
    assign word_idx = req_addr >> OFF_W;
    assign mem_idx  = word_idx[IDX_W-1:0];
    assign cur_word = mem_q[mem_idx];

    always_comb begin
        err_code = ERR_NONE;
        if ((req_addr & ADDR_W'(LANES - 1)) != '0) err_code = ERR_MISALIGN;
        else if (word_idx >= ADDR_W'(DEPTH))       err_code = ERR_RANGE;
    end

    assign err = (err_code != ERR_NONE);

    always_comb begin
        merged_word = cur_word;
        for (int l = 0; l < LANES; l++) begin
            if (req_be[l]) merged_word[8*l +: 8] = req_wdata[8*l +: 8];
        end
    end

    assign rsp_word = err ? '0 : (req_we ? merged_word : cur_word);
    assign wr_en    = acc && req_we && !err;

    always_ff @(posedge clk) begin
        if (wr_en) mem_q[mem_idx] <= merged_word;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                                          verify_q <= '0;
        else if (wr_en && word_idx == ADDR_W'(VERIFY_WORD)) verify_q <= merged_word;
    end

    // Credits: one per free response-buffer slot not yet claimed by an in-flight request.
    always_comb begin
        crd_d = crd_q;
        if (acc && !pop)      crd_d = crd_q - CRD_W'(1);
        else if (pop && !acc) crd_d = crd_q + CRD_W'(1);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) crd_q <= CRD_W'(RSP_DEPTH);
        else      crd_q <= crd_d;
    end

    // Latency pipeline: stage 0 captures the access result at the acceptance edge.
    always_comb begin
        vld_d    = vld_q << 1;
        vld_d[0] = acc;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) vld_q <= '0;
        else      vld_q <= vld_d;
    end

    always_ff @(posedge clk) begin
        rsp_q[0] <= {err, rsp_word};
        for (int i = 1; i < LATENCY; i++) rsp_q[i] <= rsp_q[i-1];
    end

    // Credits already prevent overflow; the full guard keeps the buffer intact regardless.
    assign fifo_push = vld_q[LATENCY-1] && (!fifo_full || pop);

    data_mem_pipe_rsp_fifo #(
        .WIDTH (RSP_W),
        .DEPTH (RSP_DEPTH)
    ) u_rsp_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (fifo_push),
        .pop_i   (pop),
        .data_i  (rsp_q[LATENCY-1]),
        .data_o  (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_cnt)
    );

    assign rsp_valid = !fifo_empty;
    assign {rsp_err, rsp_rdata} = (fifo_cnt != '0) ? fifo_head : '0;
    assign verify = verify_q;

endmodule

// File: tb/tb_data_mem_pipe.sv
// Directed bench for data_mem_pipe: latency, byte merge, backpressure, errors, verify, reset.
module tb_data_mem_pipe;

    localparam int DW    = 32;
    localparam int AW    = 32;
    localparam int DEPTH = 256;
    localparam int LAT   = 2;
    localparam int RD    = 2;
    localparam int VW    = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid, req_ready, req_we;
    logic [DW/8-1:0] req_be;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic          rsp_valid, rsp_ready, rsp_err;
    logic [DW-1:0] rsp_rdata, verify;

    int   total = 0;
    int   bad   = 0;
    logic stale;

    always #5 clk = ~clk;

    data_mem_pipe #(
        .DATA_W      (DW),
        .ADDR_W      (AW),
        .DEPTH       (DEPTH),
        .LATENCY     (LAT),
        .RSP_DEPTH   (RD),
        .VERIFY_WORD (VW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_be    (req_be),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .verify    (verify)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Starts at posedge+1, returns at posedge+1 of the acceptance edge.
    task automatic issue(input logic we, input logic [3:0] be, input logic [31:0] addr,
                         input logic [31:0] wd);
        int n;
        req_we = we; req_be = be; req_addr = addr; req_wdata = wd; req_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("issue_ready", req_ready, 1);
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    // Waits for the next response (consumed with rsp_ready high); exp_wait counts
    // negedges from the acceptance edge, 3 meaning LATENCY=2 with an empty FIFO.
    task automatic get_rsp(input string tag, input logic [31:0] exp_d, input logic exp_e,
                           input int exp_wait);
        int n;
        n = 1;
        @(negedge clk);
        while (!rsp_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_vld"}, rsp_valid, 1);
        check({tag, "_data"}, rsp_rdata, exp_d);
        check({tag, "_err"}, rsp_err, exp_e);
        if (exp_wait != 0) check({tag, "_lat"}, n, exp_wait);
        @(posedge clk); #1;
    endtask

    initial begin
        rst = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_be = '0;
        req_addr = '0; req_wdata = '0; rsp_ready = 1'b1; stale = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_req_ready", req_ready, 1);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_rdata", rsp_rdata, 0);
        check("rst_rsp_err",   rsp_err,   0);
        check("rst_verify",    verify,    0);
        rst = 1'b1;
        @(posedge clk); #1;

        // 1: full write then back-to-back read of the same word
        req_we = 1'b1; req_be = 4'hF; req_addr = 32'h10; req_wdata = 32'hDEADBEEF; req_valid = 1'b1;
        @(negedge clk); check("t1_rdy_a", req_ready, 1);
        @(posedge clk); #1;
        req_we = 1'b0; req_be = 4'h0; req_wdata = '0;
        @(negedge clk); check("t1_vld_e0", rsp_valid, 0); check("t1_rdy_b", req_ready, 1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(negedge clk); check("t1_vld_e1", rsp_valid, 0); check("t1_rdy_c", req_ready, 0);
        @(posedge clk);
        @(negedge clk);
        check("t1_wr_vld", rsp_valid, 1); check("t1_wr_data", rsp_rdata, 32'hDEADBEEF);
        check("t1_wr_err", rsp_err, 0);
        @(posedge clk);
        @(negedge clk);
        check("t1_rd_vld", rsp_valid, 1); check("t1_rd_data", rsp_rdata, 32'hDEADBEEF);
        check("t1_rd_err", rsp_err, 0);   check("t1_rdy_d", req_ready, 1);
        @(posedge clk);
        @(negedge clk);
        check("t1_vld_end", rsp_valid, 0); check("t1_rdy_e", req_ready, 1);
        @(posedge clk); #1;

        // 2: partial write merges only lane 0
        issue(1'b1, 4'b0001, 32'h10, 32'h000000AA);
        get_rsp("t2_wr", 32'hDEADBEAA, 1'b0, 3);
        issue(1'b0, 4'h0, 32'h10, 32'h0);
        get_rsp("t2_rd", 32'hDEADBEAA, 1'b0, 3);
        issue(1'b1, 4'hF, 32'h14, 32'h11112222);
        get_rsp("prep_14", 32'h11112222, 1'b0, 0);
        issue(1'b1, 4'hF, 32'h18, 32'h33334444);
        get_rsp("prep_18", 32'h33334444, 1'b0, 0);
        issue(1'b1, 4'hF, 32'h0, 32'h0BADF00D);
        get_rsp("prep_00", 32'h0BADF00D, 1'b0, 0);

        // 3: backpressure with three back-to-back reads
        rsp_ready = 1'b0;
        req_we = 1'b0; req_be = 4'h0; req_addr = 32'h10; req_valid = 1'b1;
        @(negedge clk); check("t3_rdy_a", req_ready, 1);
        @(posedge clk); #1; req_addr = 32'h14;
        @(negedge clk); check("t3_rdy_b", req_ready, 1);
        @(posedge clk); #1; req_addr = 32'h18;
        @(negedge clk); check("t3_rdy_c", req_ready, 0);
        @(posedge clk); #1;
        @(negedge clk);
        check("t3_rdy_d", req_ready, 0); check("t3_vld", rsp_valid, 1);
        check("t3_head_a", rsp_rdata, 32'hDEADBEAA);
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(negedge clk);
        check("t3_rdy_e", req_ready, 0); check("t3_head_b", rsp_rdata, 32'hDEADBEAA);
        @(posedge clk); #1; rsp_ready = 1'b1;
        @(negedge clk); check("t3_rdy_f", req_ready, 0);
        @(posedge clk); #1;
        @(negedge clk);
        check("t3_rdy_pop", req_ready, 1); check("t3_head_c", rsp_rdata, 32'h11112222);
        @(posedge clk); #1; req_valid = 1'b0;
        get_rsp("t3_third", 32'h33334444, 1'b0, 3);

        // 4: misaligned read and out-of-range write (aliases word 0 if not suppressed)
        issue(1'b0, 4'h0, 32'h13, 32'h0);
        get_rsp("t4_mis", 32'h0, 1'b1, 3);
        issue(1'b1, 4'hF, 4 * DEPTH, 32'hFFFFFFFF);
        get_rsp("t4_rng", 32'h0, 1'b1, 0);
        issue(1'b0, 4'h0, 32'h0, 32'h0);
        get_rsp("t4_w0", 32'h0BADF00D, 1'b0, 0);

        // 5: verify mirror
        issue(1'b1, 4'hF, VW * 4, 32'h00000042);
        check("t5_vfy_a", verify, 32'h00000042);
        get_rsp("t5_wr_a", 32'h00000042, 1'b0, 0);
        issue(1'b1, 4'h0, VW * 4, 32'hFFFFFFFF);
        check("t5_vfy_be0", verify, 32'h00000042);
        get_rsp("t5_wr_be0", 32'h00000042, 1'b0, 0);
        issue(1'b1, 4'b0010, VW * 4, 32'h00003300);
        check("t5_vfy_lane1", verify, 32'h00003342);
        get_rsp("t5_wr_lane1", 32'h00003342, 1'b0, 0);

        // 6: reset with two responses in flight
        req_we = 1'b0; req_be = 4'h0; req_addr = 32'h10; req_valid = 1'b1;
        @(posedge clk); #1; req_addr = 32'h14;
        @(posedge clk); #1; req_valid = 1'b0; rst = 1'b0;
        #1;
        check("t6_vld",    rsp_valid, 0);
        check("t6_rdy",    req_ready, 1);
        check("t6_verify", verify,    0);
        check("t6_rdata",  rsp_rdata, 0);
        @(posedge clk); #1; rst = 1'b1;
        repeat (6) begin
            @(negedge clk);
            stale = stale | rsp_valid;
        end
        check("t6_stale", stale, 0);
        @(posedge clk); #1;
        issue(1'b0, 4'h0, 32'h10, 32'h0);
        get_rsp("t6_rd10", 32'hDEADBEAA, 1'b0, 3);
        issue(1'b0, 4'h0, VW * 4, 32'h0);
        get_rsp("t6_rdvw", 32'h00003342, 1'b0, 3);
        check("t6_verify_after", verify, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
